// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, baud divisor helper and
// the legal ranges for the frame-format parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;
  localparam int OVERSAMPLE_MIN = 8;

  // Rounded clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    int q;
    den = baud * os;
    q   = (clk_hz + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, realigned by a
// synchronous restart so the first tick lands DIV clocks after it.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with one-entry ready/valid holding register.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop bits.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 12000000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int DIV = calc_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
  end

  rx_state_t            state, state_next;
  logic                 sync_1, sync_2, line_q;
  logic                 line, fall;
  logic                 tick, restart, bit_end;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx, stop_bad;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_done, frame_bad, par_bad, word_ok;

  // Two synchroniser stages plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync_1 <= rx;
      sync_2 <= sync_1;
      line_q <= sync_2;
    end
  end

  assign line = sync_2;
  assign fall = line_q & ~sync_2;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    frame_done = 1'b0;
    // Start bit is sampled at its midpoint; every later bit one full period on.
    bit_end    = tick && (tick_cnt == ((state == ST_START) ? HALF_LAST : FULL_LAST));
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
          restart    = 1'b1;
        end
      end
      ST_START: if (bit_end) state_next = line ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bit_end && bit_idx == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bit_end) state_next = ST_STOP;
`else
      ST_PARITY: state_next = ST_IDLE;
`endif
      ST_STOP: begin
        if (bit_end && stop_idx == STOP_LAST) begin
          frame_done = 1'b1;
          state_next = frame_bad ? ST_BREAK : ST_IDLE;
        end
      end
      ST_BREAK: if (line) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign frame_bad = stop_bad | ~line;
  assign word_ok   = frame_done & ~frame_bad & ~par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      shreg    <= '0;
    end else begin
      if (state == ST_IDLE)   tick_cnt <= '0;
      else if (tick)          tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
      if (state == ST_IDLE) begin
        stop_idx <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (state == ST_START && bit_end) bit_idx <= '0;
      if (state == ST_DATA && bit_end) begin
        shreg   <= {line, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      if (state == ST_STOP && bit_end) begin
        stop_idx <= stop_idx + 1'b1;
        stop_bad <= stop_bad | ~line;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  assign par_bad = ((^shreg) ^ par_bit) != 1'(PARITY_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == ST_PARITY && bit_end) par_bit <= line;
      parity_err <= frame_done & ~frame_bad & par_bad;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Holding register: a completing word may replace one accepted this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_done & frame_bad;
      overrun_err <= word_ok & rx_valid & ~rx_ready;
      if (word_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frame-level model predicts each word/error event and
// when it must appear; define UART_RX_PARITY_EN to run the parity build.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int OS     = 16;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7, SB = 2, PO = 1, PB = 1;
  localparam int LAT_EXP = 1680;
`else
  localparam int DB = 8, SB = 1, PO = 0, PB = 0;
  localparam int LAT_EXP = 1520;
`endif
  localparam int BT  = CLK_HZ / BAUD;
  localparam int TOL = 8;
  localparam int W   = DB + 2;
  localparam logic [1:0] EV_WORD = 2'd0, EV_FRAME = 2'd1, EV_PAR = 2'd2, EV_OVR = 2'd3;

  logic          clk = 1'b0;
  logic          rst, rx, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, overrun_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [W-1:0] exp_q[$];
  int           exp_t[$];
  bit            mdl_held;
  int            frame_pulses, parity_pulses, frame_start, last_cycle;
  logic [DB-1:0] last_word, prev_data;
  logic          prev_valid, prev_ready;

  uart_rx_cfg #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .OVERSAMPLE      (OS),
    .DATA_BITS       (DB),
    .STOP_BITS       (SB),
    .PARITY_ODD      (PO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  function automatic logic [DB-1:0] mask(input logic [8:0] v);
    return v[DB-1:0];
  endfunction

  function automatic logic model_parity(input logic [DB-1:0] d);
    return (^d) ^ 1'(PO);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BT) @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input logic [8:0] data, input bit bad_stop,
                            input bit flip_par, input bit hold_low);
    logic [DB-1:0] d;
    logic [1:0]    kind;
    int            due;
    d = mask(data);
    @(posedge clk);
    #1;
    frame_start = cyc;
    // Completion is judged at the midpoint of the last stop bit.
    due = cyc + (DB + PB + SB) * BT + BT / 2;
    if (bad_stop)                    kind = EV_FRAME;
    else if (flip_par)               kind = EV_PAR;
    else if (mdl_held && !rx_ready)  kind = EV_OVR;
    else begin
      kind     = EV_WORD;
      mdl_held = !rx_ready;
    end
    exp_q.push_back({kind, (kind == EV_WORD) ? d : {DB{1'b0}}});
    exp_t.push_back(due);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(model_parity(d) ^ flip_par);
    for (int i = 0; i < SB; i++) drive_bit(!bad_stop);
    if (!hold_low) rx = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_event(input logic [1:0] kind, input logic [DB-1:0] d);
    logic [W-1:0] e;
    int           t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_unexpected: got kind %0d data %0h at cycle %0d, required none",
               kind, d, cyc);
    end else begin
      e = exp_q.pop_front();
      t = exp_t.pop_front();
      if (e != {kind, d}) begin
        n_fail++;
        $display("FAIL event_value: got kind %0d data %0h, required kind %0d data %0h",
                 kind, d, e[W-1:DB], e[DB-1:0]);
      end
      n_tests++;
      if (cyc < t - TOL || cyc > t + TOL) begin
        n_fail++;
        $display("FAIL event_time: got cycle %0d, required %0d +/- %0d", cyc, t, TOL);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
    end else begin
      if (rx_valid && !prev_valid) begin
        check_event(EV_WORD, rx_data);
        last_word  = rx_data;
        last_cycle = cyc;
      end
      if (frame_err) begin
        frame_pulses++;
        check_event(EV_FRAME, '0);
      end
      if (parity_err) begin
        parity_pulses++;
        check_event(EV_PAR, '0);
      end
      if (overrun_err) check_event(EV_OVR, '0);
      if (prev_valid && !prev_ready && rx_valid)
        check("held_data_stable", int'(rx_data), int'(prev_data));
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    mdl_held = 1'b0; frame_pulses = 0; parity_pulses = 0;
    last_word = '0; last_cycle = 0; frame_start = 0;
    wait_cycles(3);
    check("reset_flags", int'({rx_valid, frame_err, parity_err, overrun_err}), 0);
    check("reset_data", int'(rx_data), 0);
    rst = 1'b0;
    wait_cycles(20);
    check("idle_after_reset", int'({rx_valid, frame_err, parity_err, overrun_err}), 0);

    // basic frame
    send_frame(9'h0A5, 1'b0, 1'b0, 1'b0);
    wait_cycles(200);
    check("basic_data", int'(last_word), int'(mask(9'h0A5)));
    check("basic_latency_near", int'((last_cycle - frame_start) >= LAT_EXP - 10 &&
                                     (last_cycle - frame_start) <= LAT_EXP + 10), 1);
    check("basic_drained", exp_q.size(), 0);

    // glitch shorter than half a bit
    frame_pulses = 0;
    @(posedge clk); #1;
    rx = 1'b0;
    wait_cycles(30);
    rx = 1'b1;
    wait_cycles(400);
    check("glitch_state_idle", int'(dut.state), int'(ST_IDLE));
    check("glitch_no_frame_err", frame_pulses, 0);
    check("glitch_no_valid", int'(rx_valid), 0);

    // framing error followed by a long break
    send_frame(9'h03C, 1'b1, 1'b0, 1'b1);
    wait_cycles(20 * BT);
    rx = 1'b1;
    wait_cycles(200);
    check("break_one_frame_err", frame_pulses, 1);
    check("break_drained", exp_q.size(), 0);
    send_frame(9'h011, 1'b0, 1'b0, 1'b0);
    wait_cycles(200);
    check("after_break_data", int'(last_word), int'(mask(9'h011)));

    // overrun: second word dropped, first kept
    rx_ready = 1'b0;
    send_frame(9'h001, 1'b0, 1'b0, 1'b0);
    send_frame(9'h002, 1'b0, 1'b0, 1'b0);
    wait_cycles(50);
    check("overrun_valid_held", int'(rx_valid), 1);
    check("overrun_data_kept", int'(rx_data), int'(mask(9'h001)));
    check("overrun_drained", exp_q.size(), 0);
    rx_ready = 1'b1;
    mdl_held = 1'b0;
    wait_cycles(1);
    check("accept_drops_valid", int'(rx_valid), 0);

`ifdef UART_RX_PARITY_EN
    check("model_parity_0x55_odd", int'(model_parity(mask(9'h055))), 1);
    parity_pulses = 0;
    send_frame(9'h055, 1'b0, 1'b0, 1'b0);
    wait_cycles(200);
    check("parity_good_data", int'(last_word), int'(mask(9'h055)));
    send_frame(9'h055, 1'b0, 1'b1, 1'b0);
    wait_cycles(200);
    check("parity_bad_pulse", parity_pulses, 1);
    check("parity_drained", exp_q.size(), 0);
`endif

    // reset in the middle of data bit 4 with a word held
    rx_ready = 1'b0;
    send_frame(9'h05A, 1'b0, 1'b0, 1'b0);
    wait_cycles(20);
    check("pre_reset_valid", int'(rx_valid), 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    wait_cycles(BT / 2);
    rst = 1'b1;
    #1;
    check("midreset_flags", int'({rx_valid, frame_err, parity_err, overrun_err}), 0);
    check("midreset_data", int'(rx_data), 0);
    exp_q.delete();
    exp_t.delete();
    mdl_held = 1'b0;
    rx_ready = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(50);
    send_frame(9'h0FF, 1'b0, 1'b0, 1'b0);
    wait_cycles(200);
    check("after_reset_data", int'(last_word), int'(mask(9'h0FF)));
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
